// File: rtl/serializador_pkg.sv
// Shared types and constants for the serializador block.
//   ser_state_t     : serializer FSM encoding (IDLE, SHIFT, GAP)
//   SER_DATA_W_DEF  : default word width
//   SER_CNT_W       : width of the optional completed-word counter
package serializador_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

   localparam int SER_DATA_W_DEF = 8;
   localparam int SER_CNT_W      = 16;

endpackage

// File: rtl/buffer_entrada.sv
// Input FIFO of the serializer: DATA_W x BUF_DEPTH synchronous FIFO.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset, empties the FIFO
//   push_i   : producer offers data_i (taken only while ready_o=1)
//   data_i   : word to store
//   pop_i    : consumer takes the head word (ignored when empty)
//   data_o   : head word
//   empty_o  : no stored words
//   ready_o  : registered !full, used as the producer-side ready
module buffer_entrada #(
   parameter int DATA_W    = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o,
   output logic              ready_o
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int PW = AW + 1;

   // Pointers carry one extra wrap bit: equal pointers mean empty,
   // pointers differing only in the wrap bit mean full.
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              ready_q;
   logic              full_d;
   logic              do_push, do_pop;
   logic [DATA_W-1:0] mem_q [BUF_DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && ready_q;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   // ready is computed from the post-update pointers, so a pop while full
   // only reopens the FIFO from the following cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ready_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ready_q  <= !full_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign ready_o = ready_q;

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial stage: buffers producer words in buffer_entrada and
// shifts each word out as DATA_W consecutive strobed bits followed by a
// one-cycle delimiter gap. A new word only starts while status_in is low.
// Ports:
//   clk_100KHz : clock, rising edge
//   reset      : asynchronous active-high reset
//   byte_in    : parallel word from producer
//   byte_valid : producer offers byte_in
//   byte_ready : FIFO can accept (registered)
//   status_in  : downstream busy; blocks starting a new word
//   data_out   : serial bit, valid while write_out=1 (registered)
//   write_out  : bit strobe (registered)
//   busy       : FIFO non-empty or word in flight
//   tx_count   : completed words, only when SER_TX_COUNT_EN is defined
//
// state | meaning
// IDLE  | waiting for a buffered word and status_in low
// SHIFT | one bit strobed per cycle, DATA_W cycles
// GAP   | single delimiter cycle with write_out=0
module serializador
   import serializador_pkg::*;
#(
   parameter int DATA_W    = SER_DATA_W_DEF,
   parameter int BUF_DEPTH = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk_100KHz,
   input  logic              reset,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic              status_in,
   output logic              data_out,
   output logic              write_out,
   output logic              busy
`ifdef SER_TX_COUNT_EN
   ,
   output logic [SER_CNT_W-1:0] tx_count
`endif
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

   ser_state_t        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              write_out_q, write_out_d;
   logic              data_out_q, data_out_d;
   logic [CW-1:0]     bit_idx;
   logic              fifo_pop;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   buffer_entrada #(
      .DATA_W    (DATA_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buffer_entrada (
      .clk_i   (clk_100KHz),
      .rst_i   (reset),
      .push_i  (byte_valid),
      .data_i  (byte_in),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .ready_o (byte_ready)
   );

   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         write_out_q <= 1'b0;
         data_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         write_out_q <= write_out_d;
         data_out_q  <= data_out_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      fifo_pop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !status_in) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_head;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // status_in deliberately ignored: a started word always completes
            if (bit_cnt_q == LAST_BIT) state_d = GAP;
            else                       bit_cnt_d = bit_cnt_q + CW'(1);
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state so that the registered
   // strobe lines up with the cycle spent in SHIFT.
   always_comb begin
      bit_idx     = MSB_FIRST ? (LAST_BIT - bit_cnt_d) : bit_cnt_d;
      write_out_d = (state_d == SHIFT);
      data_out_d  = write_out_d ? shift_d[bit_idx] : 1'b0;
   end

   assign write_out = write_out_q;
   assign data_out  = data_out_q;
   assign busy      = !fifo_empty || (state_q != IDLE);

`ifdef SER_TX_COUNT_EN
   logic [SER_CNT_W-1:0] tx_cnt_q;

   always_ff @(posedge clk_100KHz or posedge reset) begin
      if (reset)               tx_cnt_q <= '0;
      else if (state_q == GAP) tx_cnt_q <= tx_cnt_q + SER_CNT_W'(1);
   end

   assign tx_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_serializador.sv
module tb_serializador;

   localparam int W     = 8;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] byte_in = '0;
   logic       byte_valid = 1'b0;
   logic       status_in = 1'b0;
   logic       ready_a, data_a, write_a, busy_a;
   logic       ready_b, data_b, write_b, busy_b;
`ifdef SER_TX_COUNT_EN
   logic [15:0] txc_a, txc_b;
`endif

   always #5 clk = ~clk;

   // MSB-first instance
   serializador #(.DATA_W(W), .BUF_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_a (
      .clk_100KHz (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (ready_a),
      .status_in  (status_in),
      .data_out   (data_a),
      .write_out  (write_a),
      .busy       (busy_a)
`ifdef SER_TX_COUNT_EN
      ,
      .tx_count   (txc_a)
`endif
   );

   // LSB-first instance, same stimulus
   serializador #(.DATA_W(W), .BUF_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_b (
      .clk_100KHz (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (ready_b),
      .status_in  (status_in),
      .data_out   (data_b),
      .write_out  (write_b),
      .busy       (busy_b)
`ifdef SER_TX_COUNT_EN
      ,
      .tx_count   (txc_b)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a queue of buffered words plus the position inside the
   // word being sent (-1 idle, 0..W-1 strobed bit, W delimiter gap).
   logic [7:0] mq[$];
   int         pos = -1;
   logic [7:0] cur = '0;
   logic       exp_ready = 1'b1;
   int         exp_tx = 0;
   logic       acc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         pos       = -1;
         cur       = '0;
         exp_ready = 1'b1;
         exp_tx    = 0;
      end else begin
         acc = byte_valid && exp_ready;
         if (pos == -1) begin
            if (mq.size() > 0 && !status_in) begin
               cur = mq.pop_front();
               pos = 0;
            end
         end else if (pos < W) begin
            pos++;
         end else begin
            pos    = -1;
            exp_tx = (exp_tx + 1) % 65536;
         end
         if (acc) mq.push_back(byte_in);
         exp_ready = (mq.size() < DEPTH);
      end
   end

   function automatic logic m_wr();
      return (pos >= 0) && (pos < W);
   endfunction

   function automatic logic m_da();
      return m_wr() ? cur[W-1-pos] : 1'b0;
   endfunction

   function automatic logic m_db();
      return m_wr() ? cur[pos] : 1'b0;
   endfunction

   function automatic logic m_busy();
      return (mq.size() > 0) || (pos != -1);
   endfunction

   task automatic check_model();
      chk("ready_a", ready_a, exp_ready);
      chk("ready_b", ready_b, exp_ready);
      chk("write_a", write_a, m_wr());
      chk("write_b", write_b, m_wr());
      chk("data_a", data_a, m_da());
      chk("data_b", data_b, m_db());
      chk("busy_a", busy_a, m_busy());
      chk("busy_b", busy_b, m_busy());
`ifdef SER_TX_COUNT_EN
      chk("txc_a", txc_a, exp_tx);
      chk("txc_b", txc_b, exp_tx);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic push(input logic [7:0] v);
      byte_valid = 1'b1;
      byte_in    = v;
      step();
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", ready_a, 1);
      chk("rst_write", write_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_busy", busy_a, 0);
`ifdef SER_TX_COUNT_EN
      chk("rst_txc", txc_a, 0);
`endif
   endtask

   task automatic wait_strobe(input string tag);
      int k = 0;
      while (!write_a && k < 30) begin
         step();
         k++;
      end
      chk(tag, write_a, 1);
   endtask

   // Called on the first strobed cycle; returns with the gap cycle visible.
   task automatic collect(output logic [7:0] wa, output logic [7:0] wb, output int nstr);
      wa = '0;
      wb = '0;
      nstr = 0;
      for (int i = 0; i < W; i++) begin
         nstr += int'(write_a);
         wa = {wa[6:0], data_a};
         wb = {data_b, wb[7:1]};
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] wa, wb;
      int         nstr;
      int         rises[$];
      logic       prev;
      logic       first_b;

      do_reset();

      // 1: single word, latency, bit order, gap, busy release
      push(8'hA5);
      step();
      chk("t1_lat", write_a, 1);
      collect(wa, wb, nstr);
      chk("t1_word", wa, 8'hA5);
      chk("t1_nstr", nstr, 8);
      chk("t1_gap_wr", write_a, 0);
      chk("t1_gap_d", data_a, 0);
      step();
      chk("t1_busy", busy_a, 0);

      // 2: status held so both words stay queued and the FIFO fills
      status_in = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'h3C;
      step();
      byte_in = 8'hFF;
      step();
      byte_valid = 1'b0;
      chk("t2_full", ready_a, 0);
      status_in = 1'b0;
      prev = write_a;
      for (int k = 0; k < 30; k++) begin
         step();
         if (write_a && !prev) rises.push_back(k);
         prev = write_a;
      end
      chk("t2_nwords", rises.size(), 2);
      if (rises.size() == 2) chk("t2_space", rises[1] - rises[0], W + 2);

      // 3: status stall, release, then raise mid-word
      status_in = 1'b1;
      push(8'h81);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_stall", write_a, 0);
      end
      status_in = 1'b0;
      step();
      chk("t3_start", write_a, 1);
      nstr = 1;
      for (int k = 0; k < 12; k++) begin
         if (k == 2) status_in = 1'b1;
         step();
         nstr += int'(write_a);
      end
      chk("t3_nstr", nstr, 8);
      status_in = 1'b0;
      repeat (3) step();

      // 4: reset during the 4th bit
      push(8'hF0);
      wait_strobe("t4_wait1");
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      chk("t4_wr", write_a, 0);
      chk("t4_ready", ready_a, 1);
      chk("t4_busy", busy_a, 0);
      @(negedge clk);
      reset = 1'b0;
      push(8'h0F);
      wait_strobe("t4_wait2");
      collect(wa, wb, nstr);
      chk("t4_word", wa, 8'h0F);
      chk("t4_nstr", nstr, 8);
      repeat (2) step();

      // 5: LSB-first instance
      push(8'h01);
      wait_strobe("t5_wait");
      first_b = data_b;
      collect(wa, wb, nstr);
      chk("t5_first", first_b, 1);
      chk("t5_word", wb, 8'h01);
      chk("t5_msb_a", wa, 8'h01);
      repeat (2) step();

`ifdef SER_TX_COUNT_EN
      // 6: completed-word counter
      do_reset();
      for (int n = 0; n < 3; n++) begin
         push(8'h55 + n[7:0]);
         repeat (W + 3) step();
      end
      chk("t6_txc", txc_a, 3);
`endif

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         byte_valid = ($urandom_range(0, 1) == 1);
         byte_in    = 8'($urandom());
         status_in  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1;
            #2;
            chk("rnd_rst_wr", write_a, 0);
            chk("rnd_rst_busy", busy_a, 0);
            reset = 1'b0;
         end
         step();
      end
      byte_valid = 1'b0;
      status_in  = 1'b0;
      repeat (30) step();
      chk("drain_busy", busy_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
